data_ram: RTL
=============

Name: data_ram

Overview:
- Data-side memory that consumes the CPU's ram_ce/ram_we/ram_addr/ram_sel/ram_data_o port and returns ram_data_i.
- Byte-laned word RAM plus a small memory-mapped I/O window: GPIO output register, free-running cycle counter, and a compare-match timer with interrupt flag.
- Read data is combinational, because the mem stage consumes it in the same cycle. All state updates occur on the rising clock edge.

Parameters:
- ADDR_WIDTH, 10, word-address bits of RAM (default 1024 words = 4 KB).
- MMIO_BASE, 32'hFFFF_0000, base byte address of the 64 KB I/O window (addr[31:16] match).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- ce  input  1  access enable (from ram_ce)
- we  input  1  write enable, valid when ce=1
- addr  input  32  byte address; addr[1:0] ignored (word aligned)
- sel  input  4  byte lanes: sel[3]=data[31:24] (byte offset 0, big-endian) … sel[0]=data[7:0]
- data_i  input  32  write data (from ram_data_o)
- data_o  output  32  read data (to ram_data_i)
- gpio_o  output  32  GPIO output register
- timer_irq  output  1  timer interrupt, level

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - gpio_o=0, cycle_cnt=0, timer_cnt=0, timer_cmp=0, timer_ctrl=0, timer_irq=0.
  - RAM contents are not cleared.
  - data_o follows the read rules below; with ce=0 it is 0.
- Decode:
  - I/O hit when addr[31:16]==MMIO_BASE[31:16].
  - Otherwise RAM, indexed by addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses alias modulo RAM size.
- Reads:
  - ce=0 → data_o=0.
  - ce=1 → data_o is the full 32-bit word combinationally, regardless of sel. The mem stage extracts bytes and halfwords.
- Writes: at posedge when ce=1 and we=1, only lanes with sel[i]=1 are updated. sel=0000 writes nothing.
- Read-during-write, same address: data_o shows the old value in that cycle and the new value from the next cycle.
- I/O registers (offset = addr[15:0]):
  - 0x00 GPIO_OUT: rw, byte-laned.
  - 0x04 CYCLE_CNT: ro. Increments every cycle after reset, wraps 0xFFFFFFFF→0. Writes ignored.
  - 0x08 TIMER_CMP: rw.
  - 0x0C TIMER_CTRL: bit0 EN, bit1 MATCH (read; write 1 clears), bit2 AUTO_RELOAD, bit3 IRQ_EN. Bits 31:4 read 0.
  - 0x10 TIMER_CNT: rw.
  - Any other offset: reads 0, writes ignored.
- Timer:
  - While EN=1, timer_cnt increments by 1 per cycle.
  - On the cycle timer_cnt==timer_cmp with EN=1: set MATCH next edge.
  - If AUTO_RELOAD=1, timer_cnt<=0 at that edge.
  - If AUTO_RELOAD=0, EN<=0 and timer_cnt holds the compare value.
  - timer_irq = MATCH & IRQ_EN, registered state, no combinational path from the bus.
- Simultaneous events:
  - Software write to TIMER_CNT beats the increment/reload in the same cycle.
  - Hardware MATCH set beats a write-1-clear in the same cycle.
  - A TIMER_CTRL write setting EN=1 takes effect from the next cycle; the counter does not increment in the write cycle.
- Reset asserted mid-count or mid-write: all registers take reset values at that edge. No RAM write occurs in a cycle with rst=1.
- Latency: write visible on data_o 1 cycle after the write edge; MATCH/timer_irq 1 cycle after compare equality.

Optional Feature:
- Macro DATA_RAM_TIMER_EN.
- Defined: TIMER_CMP, TIMER_CTRL and TIMER_CNT are implemented as above.
- Undefined:
  - Offsets 0x08–0x10 read 0 and ignore writes.
  - timer_irq is tied to 0.
  - No timer flops are inferred.
  - GPIO_OUT and CYCLE_CNT are unaffected.

Test Plan:
- Byte-lane write: write 0x11223344 with sel=1111 to 0x40, then write 0xAABBCCDD with sel=1000 to 0x40 → read 0x40 returns 0xAA223344; sel=0011 write of 0x0000BEEF → 0xAA22BEEF.
- Aliasing and ce: with ADDR_WIDTH=10, write 0xCAFEF00D to 0x1000 → read 0x0000 returns 0xCAFEF00D; same read with ce=0 → data_o=0.
- Read-during-write: write 0x5 to 0x80 holding 0x3 → data_o=0x3 in the write cycle, 0x5 the next cycle.
- Cycle counter: release reset, wait 100 cycles → CYCLE_CNT read = 100 (±0 from first post-reset edge); a write to 0xFFFF0004 has no effect.
- Timer one-shot:
  - Setup: CMP=5, CTRL=0b1001 (EN, IRQ_EN).
  - Response: MATCH set and timer_irq=1 six cycles after EN takes effect; EN reads 0; TIMER_CNT=5.
  - Clear: write CTRL=0b0010 → timer_irq=0 next cycle.
- Timer auto-reload with conflict: CMP=3, CTRL=0b0101 → MATCH every 4 cycles and counter sequence 0,1,2,3,0. A w1c issued in a match cycle leaves MATCH=1. Reset asserted mid-count → all timer regs 0 and timer_irq=0.

Source files
------------

// File: rtl/data_ram.sv
// data_ram: data-side memory for the CPU mem stage.
// Byte-laned word RAM plus a 64 KB MMIO window holding a GPIO output
// register, a free-running cycle counter and a compare-match timer.
// Build option: define DATA_RAM_TIMER_EN to implement the timer
// (TIMER_CMP / TIMER_CTRL / TIMER_CNT and timer_irq); without it those
// offsets read 0, writes are dropped and timer_irq is tied low.
module data_ram #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] gpio_o,
  output logic        timer_irq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // word offsets inside the I/O window (byte offset >> 2)
  localparam logic [13:0] OFS_GPIO  = 14'h0;
  localparam logic [13:0] OFS_CYCLE = 14'h1;
  localparam logic [13:0] OFS_CMP   = 14'h2;
  localparam logic [13:0] OFS_CTRL  = 14'h3;
  localparam logic [13:0] OFS_CNT   = 14'h4;

  logic [31:0] mem [DEPTH];

  logic                  ioHit;
  logic [ADDR_WIDTH-1:0] ramIdx;
  logic [13:0]           ioWord;
  logic                  wrEn, ramWr, ioWr;
  logic [31:0]           cycleCnt;
  logic [31:0]           ioRd;
  logic                  unusedAddr;

  assign ioHit  = (addr[31:16] == MMIO_BASE[31:16]);
  assign ramIdx = addr[ADDR_WIDTH+1:2];
  assign ioWord = addr[15:2];
  // a cycle with rst high never writes anything, RAM included
  assign wrEn   = ce & we & ~rst;
  assign ramWr  = wrEn & ~ioHit;
  assign ioWr   = wrEn & ioHit;
  assign unusedAddr = ^addr[1:0];

  // replace only the byte lanes enabled by sel (sel[3] = bits 31:24)
  function automatic logic [31:0] laneMerge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  lanes);
    logic [31:0] r;
    r = oldVal;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) r[8*i +: 8] = newVal[8*i +: 8];
    return r;
  endfunction

  // RAM write port; contents are deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (ramWr)
      for (int i = 0; i < 4; i++)
        if (sel[i]) mem[ramIdx][8*i +: 8] <= data_i[8*i +: 8];
  end

  // GPIO output register and free-running cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_o   <= '0;
      cycleCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (ioWr && ioWord == OFS_GPIO) gpio_o <= laneMerge(gpio_o, data_i, sel);
    end
  end

`ifdef DATA_RAM_TIMER_EN
  logic [31:0] timerCmp, timerCnt;
  logic        tEn, tMatch, tAuto, tIrqEn;
  logic        timerHit;
  logic        wrCmp, wrCtrl, wrCnt;

  assign timerHit = tEn && (timerCnt == timerCmp);
  assign wrCmp    = ioWr && ioWord == OFS_CMP;
  assign wrCtrl   = ioWr && ioWord == OFS_CTRL && sel[0];
  assign wrCnt    = ioWr && ioWord == OFS_CNT;

  // Timer: hardware update first, bus writes later in the block so they
  // override it; the one exception is MATCH, where a hardware set wins
  // over a same-cycle write-1-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      timerCmp <= '0;
      timerCnt <= '0;
      tEn      <= 1'b0;
      tMatch   <= 1'b0;
      tAuto    <= 1'b0;
      tIrqEn   <= 1'b0;
    end else begin
      if (tEn) begin
        if (timerHit) begin
          tMatch <= 1'b1;
          if (tAuto) timerCnt <= '0;
          else       tEn      <= 1'b0;
        end else begin
          timerCnt <= timerCnt + 32'd1;
        end
      end
      if (wrCmp) timerCmp <= laneMerge(timerCmp, data_i, sel);
      if (wrCnt) timerCnt <= laneMerge(timerCnt, data_i, sel);
      if (wrCtrl) begin
        tEn    <= data_i[0];
        tAuto  <= data_i[2];
        tIrqEn <= data_i[3];
        if (data_i[1] && !timerHit) tMatch <= 1'b0;
      end
    end
  end

  // both terms are flops, so no bus-to-irq combinational path exists
  assign timer_irq = tMatch & tIrqEn;

  // I/O read mux
  always_comb begin
    ioRd = '0;
    case (ioWord)
      OFS_GPIO:  ioRd = gpio_o;
      OFS_CYCLE: ioRd = cycleCnt;
      OFS_CMP:   ioRd = timerCmp;
      OFS_CTRL:  ioRd = {28'b0, tIrqEn, tAuto, tMatch, tEn};
      OFS_CNT:   ioRd = timerCnt;
      default:   ioRd = '0;
    endcase
  end
`else
  assign timer_irq = 1'b0;

  // I/O read mux (timer offsets fall into the read-as-zero default)
  always_comb begin
    ioRd = '0;
    case (ioWord)
      OFS_GPIO:  ioRd = gpio_o;
      OFS_CYCLE: ioRd = cycleCnt;
      default:   ioRd = '0;
    endcase
  end
`endif

  // combinational read: the mem stage consumes it in the same cycle
  always_comb begin
    data_o = '0;
    if (ce) data_o = ioHit ? ioRd : mem[ramIdx];
  end

endmodule
